// File: rtl/hazard_pkg.sv
// Shared types for the RV32I pipeline hazard controller.
package hazard_pkg;

  // resultSrc encoding that marks a load in E
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // E-stage operand source select
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  // Memory-wait controller state
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hz_state_t;

  // Stall/flush bundle driven onto the pipeline registers
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } pipe_ctrl_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one E-stage operand: M result beats W result, x0 never forwarded.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] rs_e_i,
  input  logic [REG_W-1:0] rd_m_i,
  input  logic [REG_W-1:0] rd_w_i,
  input  logic             reg_write_m_i,
  input  logic             reg_write_w_i,
  output fwd_sel_t         fwd_o
);

  // Priority compare against the two younger writers
  always_comb begin
    fwd_o = FWD_REG;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
      fwd_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use bubbles, branch flushes and
// a timeout-protected data-memory wait FSM.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1_D,
  input  logic [REG_W-1:0] Rs2_D,
  input  logic [REG_W-1:0] Rs1_E,
  input  logic [REG_W-1:0] Rs2_E,
  input  logic [REG_W-1:0] Rd_E,
  input  logic [REG_W-1:0] Rd_M,
  input  logic [REG_W-1:0] Rd_W,
  input  logic [1:0]       resultSrc_E,
  input  logic             regWrite_M,
  input  logic             regWrite_W,
  input  logic             PCsrc_E,
  input  logic             memReq_M,
  input  logic             memReady_M,
  output logic [1:0]       forwardA_E,
  output logic [1:0]       forwardB_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic             mem_err,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  hz_state_t   state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  pipe_ctrl_t  ctrl;
  fwd_sel_t    fwd_a, fwd_b;
  logic        lw_stall;
  logic        eval_run;
  logic        br_flush;

  hazard_fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .rs_e_i        (Rs1_E),
    .rd_m_i        (Rd_M),
    .rd_w_i        (Rd_W),
    .reg_write_m_i (regWrite_M),
    .reg_write_w_i (regWrite_W),
    .fwd_o         (fwd_a)
  );

  hazard_fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .rs_e_i        (Rs2_E),
    .rd_m_i        (Rd_M),
    .rd_w_i        (Rd_W),
    .reg_write_m_i (regWrite_M),
    .reg_write_w_i (regWrite_W),
    .fwd_o         (fwd_b)
  );

  // Load in E whose destination is read by the instruction in D
  assign lw_stall = (resultSrc_E == RESULT_SRC_LOAD) && (Rd_E != '0) &&
                    ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  // State and wait-counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stall/flush decode; branch/load-use only apply when E is free to advance
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl     = '0;
    eval_run = 1'b0;
    br_flush = 1'b0;
    unique case (state_q)
      RUN: begin
        if (memReq_M && !memReady_M) begin
          state_d      = MEM_WAIT;
          cnt_d        = WAIT_W'(1);
          ctrl.stall_f = 1'b1;
          ctrl.stall_d = 1'b1;
          ctrl.stall_e = 1'b1;
          ctrl.stall_m = 1'b1;
          ctrl.flush_w = 1'b1;
        end else begin
          eval_run = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (memReady_M) begin
          state_d  = RUN;
          cnt_d    = '0;
          eval_run = 1'b1;
        end else begin
          ctrl.stall_f = 1'b1;
          ctrl.stall_d = 1'b1;
          ctrl.stall_e = 1'b1;
          ctrl.stall_m = 1'b1;
          ctrl.flush_w = 1'b1;
          if (cnt_q == WAIT_LAST) begin
            state_d = HALT;
          end else begin
            cnt_d = cnt_q + WAIT_W'(1);
          end
        end
      end
      HALT: begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.stall_e = 1'b1;
        ctrl.stall_m = 1'b1;
        ctrl.flush_w = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (eval_run) begin
      if (PCsrc_E) begin
        ctrl.flush_d = 1'b1;
        ctrl.flush_e = 1'b1;
        br_flush     = 1'b1;
      end else if (lw_stall) begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.flush_e = 1'b1;
      end
    end
    if (!rst) begin
      ctrl         = '0;
      ctrl.flush_d = 1'b1;
      ctrl.flush_e = 1'b1;
      br_flush     = 1'b0;
    end
  end

  assign forwardA_E = rst ? fwd_a : FWD_REG;
  assign forwardB_E = rst ? fwd_b : FWD_REG;
  assign stall_F    = ctrl.stall_f;
  assign stall_D    = ctrl.stall_d;
  assign stall_E    = ctrl.stall_e;
  assign stall_M    = ctrl.stall_m;
  assign flush_D    = ctrl.flush_d;
  assign flush_E    = ctrl.flush_e;
  assign flush_W    = ctrl.flush_w;
  assign mem_err    = (state_q == HALT);

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Free-running perf counters, wrap on overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ctrl.stall_f || ctrl.stall_d || ctrl.stall_e || ctrl.stall_m) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (br_flush) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stallCycles = stall_cnt_q;
  assign flushCount  = flush_cnt_q;
`else
  logic unused_br_flush;
  assign unused_br_flush = br_flush;
  assign stallCycles     = '0;
  assign flushCount      = '0;
`endif

endmodule
